// File: rtl/fetch_prefetch_buffer_pkg.sv
// Shared fetch-stage types and constants.
//   fetch_packet_t : {pc, instr} packet handed from fetch to decode
//   NOP_INSTR      : addi x0,x0,0, presented on the packet bus when no packet is held
//   PC_STEP        : sequential fetch increment (one 32-bit word)
package fetch_prefetch_buffer_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_packet_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_prefetch_buffer_slot_ring.sv
// Slot ring for the prefetch buffer.
// A slot is allocated (pc recorded) when its request is issued, filled
// (instr recorded) when its response returns, and freed when popped.
//   clk, rst       : clock, synchronous active-high reset
//   flush          : free every slot; overrides alloc/fill/pop that cycle
//   alloc/alloc_pc : claim the tail slot for a newly issued request
//   fill/fill_instr: write the oldest allocated-but-unfilled slot
//   pop            : release the head slot
//   head_valid     : head slot allocated and filled
//   head_pkt       : head packet, {0, NOP} when head_valid is low
//   full           : all DEPTH slots allocated
module fetch_prefetch_buffer_slot_ring
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          alloc,
    input  logic [31:0]   alloc_pc,
    input  logic          fill,
    input  logic [31:0]   fill_instr,
    input  logic          pop,
    output logic          head_valid,
    output fetch_packet_t head_pkt,
    output logic          full
);

    localparam int IW = $clog2(DEPTH);

    // One extra wrap bit so equal indices can mean either empty or full.
    logic [IW:0]          head, tail, fill_ptr;
    fetch_packet_t        slot [DEPTH];
    logic [DEPTH-1:0]     filled;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            filled   <= '0;
        end else begin
            // A full ring may pop and alloc the same index in one cycle;
            // alloc never touches filled, so the pop's clear is kept.
            if (alloc) begin
                slot[tail[IW-1:0]].pc <= alloc_pc;
                tail                  <= tail + 1'b1;
            end
            if (fill) begin
                slot[fill_ptr[IW-1:0]].instr <= fill_instr;
                filled[fill_ptr[IW-1:0]]     <= 1'b1;
                fill_ptr                     <= fill_ptr + 1'b1;
            end
            if (pop) begin
                filled[head[IW-1:0]] <= 1'b0;
                head                 <= head + 1'b1;
            end
        end
    end

    // filled bits are only ever set on allocated slots, so they alone
    // qualify the head.
    assign head_valid = filled[head[IW-1:0]];
    assign head_pkt   = head_valid ? slot[head[IW-1:0]]
                                   : '{pc: 32'h0, instr: NOP_INSTR};
    assign full       = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch front end: sequential PC generation, in-order imem
// requests, slot buffering and redirect handling with stale-response drop.
//   clk, rst                        : clock, synchronous active-high reset
//   imem_req_valid/ready/addr       : request channel to instruction memory
//   imem_resp_valid/data            : in-order responses, never back-pressured
//   redirect_valid/pc               : taken branch/jump from execute
//   out_valid/ready, out_pc/instr   : packet handshake to decode
module fetch_prefetch_buffer
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          MAX_OUT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int CW = $clog2(MAX_OUT + 1);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;   // live requests whose words will be kept
    logic [CW-1:0] drop_cnt;      // stale requests whose words will be discarded
    logic [CW:0]   inflight;
    logic          full, req_fire, resp_fill, resp_drop;
    fetch_packet_t head_pkt;

    assign inflight       = {1'b0, outstanding} + {1'b0, drop_cnt};
    assign imem_req_valid = !rst && !redirect_valid && !full
                            && (inflight < (CW+1)'(MAX_OUT));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_drop      = imem_resp_valid && (drop_cnt != '0);
    assign resp_fill      = imem_resp_valid && (drop_cnt == '0);

    fetch_prefetch_buffer_slot_ring #(.DEPTH(DEPTH)) u_ring (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .alloc      (req_fire),
        .alloc_pc   (fetch_pc),
        .fill       (resp_fill),
        .fill_instr (imem_resp_data),
        .pop        (out_valid && out_ready),
        .head_valid (out_valid),
        .head_pkt   (head_pkt),
        .full       (full)
    );

    assign out_pc    = head_pkt.pc;
    assign out_instr = head_pkt.instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            outstanding <= '0;
            // Everything still in flight becomes stale. A response landing
            // this very cycle is the oldest of those and is retired here,
            // so it must not also be counted as a future drop.
            drop_cnt    <= CW'(inflight - (CW+1)'(imem_resp_valid));
        end else begin
            if (req_fire)
                fetch_pc <= fetch_pc + PC_STEP;
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_fill);
            drop_cnt    <= drop_cnt - CW'(resp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_resp_valid && (inflight == '0)));
            assert (outstanding <= CW'(MAX_OUT));
        end
    end

endmodule
